// File: rtl/dsp_mult_m_stage.sv
// Multiplier stage of the DSP slice: signed 25x18 product split into two partial products,
// with an optional M pipeline register and the recombined 43-bit product for observation.
module dsp_mult_m_stage #(
  parameter int    MREG     = 1,
  parameter string USE_MULT = "MULTIPLY"
) (
  input  logic        CLK,
  input  logic        RSTM,
  input  logic        CEM,
  input  logic [24:0] A_MULT,
  input  logic [17:0] B_MULT,
  output logic [42:0] PP_LO,
  output logic [42:0] PP_HI,
  output logic [42:0] M,
  output logic        M_VALID
);

  localparam bit MULT_EN = (USE_MULT == "MULTIPLY");

  generate
    if (MREG != 0 && MREG != 1) begin : g_bad_mreg
      $error("dsp_mult_m_stage: MREG must be 0 or 1");
    end
    if (USE_MULT != "MULTIPLY" && USE_MULT != "NONE") begin : g_bad_use_mult
      $error("dsp_mult_m_stage: USE_MULT must be \"MULTIPLY\" or \"NONE\"");
    end
  endgenerate

  logic signed [24:0] a_s;
  logic signed [8:0]  b_hi_s;
  logic signed [42:0] a_x;
  logic signed [42:0] b_lo_x;
  logic signed [42:0] b_hi_x;
  logic signed [42:0] pp_lo_c;
  logic signed [42:0] pp_hi_c;

  // Every operand is widened to 43 bits first, so each product is exact before truncation.
  assign a_s     = A_MULT;
  assign b_hi_s  = B_MULT[17:9];
  assign a_x     = 43'(a_s);
  assign b_lo_x  = signed'({34'd0, B_MULT[8:0]});
  assign b_hi_x  = 43'(b_hi_s);
  assign pp_lo_c = a_x * b_lo_x;
  assign pp_hi_c = (a_x * b_hi_x) <<< 9;

  logic [42:0] pp_lo_q;
  logic [42:0] pp_hi_q;
  logic        valid_q;

  always_ff @(posedge CLK) begin
    if (RSTM) begin
      pp_lo_q <= '0;
      pp_hi_q <= '0;
      valid_q <= 1'b0;
    end else if (CEM) begin
      pp_lo_q <= MULT_EN ? pp_lo_c : '0;
      pp_hi_q <= MULT_EN ? pp_hi_c : '0;
      valid_q <= MULT_EN;
    end
  end

  // With MREG=0 the register is left dangling and trimmed by synthesis.
  always_comb begin
    PP_LO   = '0;
    PP_HI   = '0;
    M_VALID = 1'b0;
    if (MULT_EN) begin
      if (MREG == 1) begin
        PP_LO   = pp_lo_q;
        PP_HI   = pp_hi_q;
        M_VALID = valid_q;
      end else begin
        PP_LO   = pp_lo_c;
        PP_HI   = pp_hi_c;
        M_VALID = 1'b1;
      end
    end
  end

  assign M = PP_LO + PP_HI;

endmodule

// File: tb/tb_dsp_mult_m_stage.sv
// Directed and random checks of dsp_mult_m_stage in its registered, combinational
// and disabled configurations.
module tb_dsp_mult_m_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [42:0] got, input logic [42:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // MREG=1 instance
  logic               rst1, ce1;
  logic signed [24:0] a1;
  logic signed [17:0] b1;
  logic [42:0]        pplo1, pphi1, m1;
  logic               v1;

  dsp_mult_m_stage #(.MREG(1), .USE_MULT("MULTIPLY")) dut_reg (
    .CLK(clk), .RSTM(rst1), .CEM(ce1), .A_MULT(a1), .B_MULT(b1),
    .PP_LO(pplo1), .PP_HI(pphi1), .M(m1), .M_VALID(v1)
  );

  // MREG=0 instance
  logic               rst0, ce0;
  logic signed [24:0] a0;
  logic signed [17:0] b0;
  logic [42:0]        pplo0, pphi0, m0;
  logic               v0;

  dsp_mult_m_stage #(.MREG(0), .USE_MULT("MULTIPLY")) dut_comb (
    .CLK(clk), .RSTM(rst0), .CEM(ce0), .A_MULT(a0), .B_MULT(b0),
    .PP_LO(pplo0), .PP_HI(pphi0), .M(m0), .M_VALID(v0)
  );

  // USE_MULT="NONE" instance
  logic               rstn, cen;
  logic signed [24:0] an;
  logic signed [17:0] bn;
  logic [42:0]        pplon, pphin, mn;
  logic               vn;

  dsp_mult_m_stage #(.MREG(1), .USE_MULT("NONE")) dut_none (
    .CLK(clk), .RSTM(rstn), .CEM(cen), .A_MULT(an), .B_MULT(bn),
    .PP_LO(pplon), .PP_HI(pphin), .M(mn), .M_VALID(vn)
  );

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  logic signed [42:0] ax, bx, exp_m;

  initial begin
    rst1 = 1'b1; ce1 = 1'b1; a1 = 25'h0000005; b1 = 18'h00003;
    rst0 = 1'b0; ce0 = 1'b0; a0 = '0; b0 = '0;
    rstn = 1'b0; cen = 1'b1; an = '0; bn = '0;

    // reset has priority over CEM
    edge1();
    check("rst_pplo", pplo1, 43'd0);
    check("rst_pphi", pphi1, 43'd0);
    check("rst_m", m1, 43'd0);
    check("rst_valid", {42'd0, v1}, 43'd0);
    rst1 = 1'b0;
    edge1();
    check("first_m", m1, 43'd15);
    check("first_pplo", pplo1, 43'd15);
    check("first_pphi", pphi1, 43'd0);
    check("first_valid", {42'd0, v1}, 43'd1);

    a1 = 25'h1FFFFFF; b1 = 18'h3FFFF;
    edge1();
    check("neg_neg", m1, 43'd1);
    a1 = 25'h0000003; b1 = 18'h3FFFE;
    edge1();
    check("pos_neg", m1, 43'h7FFFFFFFFFA);

    a1 = 25'h1000000; b1 = 18'h20000;
    edge1();
    check("max_pplo", pplo1, 43'd0);
    check("max_pphi", pphi1, 43'h20000000000);
    check("max_m", m1, 43'h20000000000);
    a1 = 25'h1000000; b1 = 18'h1FFFF;
    edge1();
    check("min_m", m1, 43'h60001000000);

    for (int i = 0; i < 1000; i++) begin
      a1 = 25'($urandom);
      b1 = 18'($urandom);
      ax = 43'(a1);
      bx = 43'(b1);
      exp_m = ax * bx;
      edge1();
      check("rand_m", m1, exp_m);
    end

    // hold with CEM=0, then reset without enable
    a1 = 25'd100; b1 = 18'd200;
    edge1();
    check("load_m", m1, 43'd20000);
    ce1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a1 = 25'd7 + 25'(i); b1 = 18'd9;
      edge1();
      check("hold_m", m1, 43'd20000);
      check("hold_valid", {42'd0, v1}, 43'd1);
    end
    rst1 = 1'b1;
    edge1();
    check("rst_nocе_m", m1, 43'd0);
    check("rst_noce_valid", {42'd0, v1}, 43'd0);
    rst1 = 1'b0; ce1 = 1'b1; a1 = 25'd6; b1 = 18'd7;
    edge1();
    check("after_rst_m", m1, 43'd42);

    // combinational instance
    a0 = -25'sd1000; b0 = 18'sd300;
    #1;
    check("comb_m", m0, 43'h7FFFFFB6C20);
    check("comb_pplo", pplo0, 43'h7FFFFFB6C20);
    check("comb_pphi", pphi0, 43'd0);
    check("comb_valid", {42'd0, v0}, 43'd1);
    rst0 = 1'b1; ce0 = 1'b1;
    edge1();
    check("comb_rst_m", m0, 43'h7FFFFFB6C20);
    check("comb_rst_valid", {42'd0, v0}, 43'd1);
    rst0 = 1'b0; ce0 = 1'b0; a0 = 25'sd3; b0 = 18'sd1000;
    #1;
    check("comb_new_m", m0, 43'd3000);
    check("comb_new_pphi", pphi0, 43'd1536);

    // disabled multiplier
    for (int i = 0; i < 50; i++) begin
      an = 25'($urandom);
      bn = 18'($urandom);
      edge1();
      check("none_m", mn, 43'd0);
      check("none_pplo", pplon, 43'd0);
      check("none_pphi", pphin, 43'd0);
      check("none_valid", {42'd0, vn}, 43'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
